// File: rtl/clk_rst_pkg.sv
// Shared constants for the clock/reset top: tick channel limits and the
// standard divide values for a 100 MHz us -> ms -> s -> min timebase.
package clk_rst_pkg;

    localparam int TICK_MAX_CH  = 8;
    localparam int TICK_CH_W    = 3;

    localparam int TICK_DIV_US  = 100;
    localparam int TICK_DIV_MS  = 1000;
    localparam int TICK_DIV_S   = 1000;
    localparam int TICK_DIV_MIN = 60;

endpackage

// File: rtl/tick_stage.sv
// One cascaded tick channel: period counter, active divide value and a
// shadow register that is only applied on a period boundary (or while held).
module tick_stage #(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 1000
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             strobe_in,
    input  logic             cfg_sel,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             wrap,
    output logic             pend
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] shd_r;
    logic             pend_r;
    logic [DIV_W-1:0] new_div_s;
    logic             wrap_s;

    // Clamp the written divide to 1 and detect the terminal count; >= keeps a
    // shrunken divide applied during hold from running off to full scale.
    always_comb begin
        if (cfg_div == {DIV_W{1'b0}}) begin
            new_div_s = DIV_ONE;
        end else begin
            new_div_s = cfg_div;
        end
        wrap_s = strobe_in & (cnt_r >= (div_r - DIV_ONE));
    end

    assign wrap = wrap_s;
    assign pend = pend_r;

    // Period counter plus shadow/active divide handover.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_r  <= {DIV_W{1'b0}};
            div_r  <= DIV_RST;
            shd_r  <= DIV_RST;
            pend_r <= 1'b0;
        end else if (sync_clr) begin
            cnt_r  <= {DIV_W{1'b0}};
            div_r  <= pend_r ? shd_r : div_r;
            pend_r <= 1'b0;
        end else begin
            if (wrap_s) begin
                cnt_r <= {DIV_W{1'b0}};
            end else if (strobe_in) begin
                cnt_r <= cnt_r + DIV_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            if (cfg_sel && wrap_s) begin
                div_r  <= new_div_s;
                shd_r  <= new_div_s;
                pend_r <= 1'b0;
            end else if (cfg_sel) begin
                shd_r  <= new_div_s;
                pend_r <= 1'b1;
            end else if (pend_r && (wrap_s || !en)) begin
                div_r  <= shd_r;
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// System timebase: base prescaler producing pluse_us and NUM_CH cascaded,
// runtime-programmable tick channels with registered strobe outputs.
module tick_gen_multi
    import clk_rst_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 1000
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic                 cfg_wr,
    input  logic [TICK_CH_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]     cfg_div,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    cfg_pend,
    output logic                 pluse_us,
    output logic [NUM_CH-1:0]    tick
);

    localparam int BASE_W = $clog2(CLK_DIV);
    localparam logic [BASE_W-1:0]    BASE_LAST = BASE_W'(CLK_DIV - 1);
    localparam logic [BASE_W-1:0]    BASE_ONE  = BASE_W'(1);
    localparam logic [TICK_CH_W:0]   CH_LIMIT  = (TICK_CH_W + 1)'(NUM_CH);

    logic [BASE_W-1:0] base_cnt_r;
    logic              base_wrap_s;
    logic              cfg_ok_s;
    logic [NUM_CH-1:0] cfg_sel_s;
    logic [NUM_CH-1:0] ch_wrap_s;
    logic [NUM_CH-1:0] pend_s;

    // Base terminal count and channel-select decode of the config write.
    always_comb begin
        base_wrap_s = en & (base_cnt_r == BASE_LAST);
        cfg_ok_s    = cfg_wr & ({1'b0, cfg_ch} < CH_LIMIT);
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_sel_s[k] = cfg_ok_s & (cfg_ch == TICK_CH_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic strobe_in_s;
        if (k == 0) begin : g_first
            assign strobe_in_s = base_wrap_s;
        end else begin : g_next
            assign strobe_in_s = ch_wrap_s[k-1];
        end

        tick_stage #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_stage (
            .clk_sys   (clk_sys),
            .rst       (rst),
            .en        (en),
            .sync_clr  (sync_clr),
            .strobe_in (strobe_in_s),
            .cfg_sel   (cfg_sel_s[k]),
            .cfg_div   (cfg_div),
            .wrap      (ch_wrap_s[k]),
            .pend      (pend_s[k])
        );
    end

    assign cfg_pend = pend_s;

    // Base prescaler and registered strobe/error outputs; a phase clear
    // suppresses any strobe that would have fired on that cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            base_cnt_r <= {BASE_W{1'b0}};
            pluse_us   <= 1'b0;
            tick       <= {NUM_CH{1'b0}};
            cfg_err    <= 1'b0;
        end else if (sync_clr) begin
            base_cnt_r <= {BASE_W{1'b0}};
            pluse_us   <= 1'b0;
            tick       <= {NUM_CH{1'b0}};
            cfg_err    <= 1'b0;
        end else begin
            if (base_wrap_s) begin
                base_cnt_r <= {BASE_W{1'b0}};
            end else if (en) begin
                base_cnt_r <= base_cnt_r + BASE_ONE;
            end else begin
                base_cnt_r <= base_cnt_r;
            end
            pluse_us <= base_wrap_s;
            tick     <= ch_wrap_s;
            cfg_err  <= cfg_wr & ~cfg_ok_s;
        end
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: a behavioural model pushes the expected
// next-cycle outputs for every driven cycle, which are popped after the edge.
module tb_tick_gen_multi;

    localparam int CLK_DIV = 4;
    localparam int NUM_CH  = 3;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 3;

    logic              clk_sys = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              sync_clr = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [2:0]        cfg_ch = 3'd0;
    logic [DIV_W-1:0]  cfg_div = 16'd0;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pend;
    logic              pluse_us;
    logic [NUM_CH-1:0] tick;

    always #5 clk_sys = ~clk_sys;

    tick_gen_multi #(
        .CLK_DIV (CLK_DIV),
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .cfg_pend (cfg_pend),
        .pluse_us (pluse_us),
        .tick     (tick)
    );

    typedef struct {
        logic       pls;
        logic [2:0] tk;
        logic       err;
        logic [2:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   out_cyc = 0;

    int   m_base;
    int   m_cnt[NUM_CH];
    int   m_div[NUM_CH];
    int   m_shd[NUM_CH];
    bit   m_pend[NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s out_cyc=%0d got=%0h exp=%0h", tag, out_cyc, obs, exp_v);
        end
    endtask

    // Behavioural model of one clock edge, written from the block's rules.
    task automatic model_step(input bit r, input bit e, input bit s, input bit w,
                              input int c, input int d);
        exp_t x;
        bit   cw[NUM_CH];
        bit   strobe;
        bit   bw;
        int   nv;
        x = '{1'b0, 3'b000, 1'b0, 3'b000};
        if (r) begin
            m_base = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_cnt[k] = 0; m_div[k] = DEF_DIV; m_shd[k] = DEF_DIV; m_pend[k] = 1'b0;
            end
        end else if (s) begin
            m_base = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_cnt[k] = 0;
                if (m_pend[k]) m_div[k] = m_shd[k];
                m_pend[k] = 1'b0;
            end
        end else begin
            bw = e && (m_base == CLK_DIV - 1);
            strobe = bw;
            for (int k = 0; k < NUM_CH; k++) begin
                cw[k] = strobe && (m_cnt[k] >= m_div[k] - 1);
                if (cw[k]) m_cnt[k] = 0;
                else if (strobe) m_cnt[k] = m_cnt[k] + 1;
                strobe = cw[k];
            end
            if (bw) m_base = 0;
            else if (e) m_base = m_base + 1;
            nv = (d == 0) ? 1 : d;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w && c == k && cw[k]) begin
                    m_div[k] = nv; m_shd[k] = nv; m_pend[k] = 1'b0;
                end else if (w && c == k) begin
                    m_shd[k] = nv; m_pend[k] = 1'b1;
                end else if (m_pend[k] && (cw[k] || !e)) begin
                    m_div[k] = m_shd[k]; m_pend[k] = 1'b0;
                end
                x.tk[k] = cw[k];
            end
            x.pls = bw;
            x.err = w && (c >= NUM_CH);
        end
        for (int k = 0; k < NUM_CH; k++) x.pend[k] = m_pend[k];
        sb_q.push_back(x);
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic drive_cycle(input bit r, input bit e, input bit s, input bit w,
                               input int c, input int d);
        exp_t x;
        rst = r; en = e; sync_clr = s; cfg_wr = w;
        cfg_ch = 3'(c); cfg_div = 16'(d);
        model_step(r, e, s, w, c, d);
        @(posedge clk_sys);
        #1;
        out_cyc = r ? 0 : cyc + 1;
        cyc = r ? 0 : cyc + 1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            chk("pluse_us", 32'(pluse_us), 32'(x.pls));
            chk("tick",     32'(tick),     32'(x.tk));
            chk("cfg_err",  32'(cfg_err),  32'(x.err));
            chk("cfg_pend", 32'(cfg_pend), 32'(x.pend));
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int first_pls;
        int first_t0;
        int first_t2;
        int t1_cnt;
        int t1_first;
        bit r_b, e_b, s_b, w_b;

        // Reset state, then free-running cascade.
        do_reset();
        chk("rst_outs", 32'({pluse_us, tick, cfg_err, cfg_pend}), 32'd0);
        first_pls = -1; first_t0 = -1; first_t2 = -1;
        for (int i = 0; i < 112; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            if (pluse_us && first_pls < 0) first_pls = out_cyc;
            if (tick[0] && first_t0 < 0) first_t0 = out_cyc;
            if (tick[2] && first_t2 < 0) first_t2 = out_cyc;
        end
        chk("first_pluse", 32'(first_pls), 32'd4);
        chk("first_tick0", 32'(first_t0), 32'd12);
        chk("first_tick2", 32'(first_t2), 32'd108);

        // Reprogram channel 1 to divide by 2 mid-period.
        do_reset();
        t1_cnt = 0; t1_first = -1;
        for (int i = 0; i < 90; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, (i == 20), 1, 2);
            if (out_cyc == 35) chk("pend1_held", 32'(cfg_pend[1]), 32'd1);
            if (out_cyc == 36) chk("pend1_clr", 32'(cfg_pend[1]), 32'd0);
            if (tick[1]) begin
                t1_cnt++;
                if (t1_first < 0) t1_first = out_cyc;
            end
        end
        chk("tick1_first", 32'(t1_first), 32'd36);
        chk("tick1_count", 32'(t1_cnt), 32'd3);

        // Zero divide on channel 0 and an out-of-range channel write.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, (i == 14) || (i == 16), (i == 16) ? 5 : 0,
                        (i == 16) ? 7 : 0);
            if (out_cyc == 17) chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        end

        // Hold for cycles 10..19.
        do_reset();
        first_pls = -1;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, !(i >= 10 && i <= 19), 1'b0, 1'b0, 0, 0);
            if (pluse_us && out_cyc > 10 && first_pls < 0) first_pls = out_cyc;
        end
        chk("hold_resume", 32'(first_pls), 32'd22);

        // Phase clear with a pending shadow, write while held, reset mid-run.
        do_reset();
        first_pls = -1;
        for (int i = 0; i < 60; i++) begin
            drive_cycle((i == 50), !(i == 40 || i == 41), (i == 30),
                        (i == 25) || (i == 40), (i == 40) ? 0 : 2, (i == 40) ? 2 : 5);
            if (pluse_us && out_cyc > 30 && first_pls < 0) first_pls = out_cyc;
            if (out_cyc == 31) chk("sclr_pend", 32'(cfg_pend), 32'd0);
        end
        chk("sclr_pluse", 32'(first_pls), 32'd35);

        // Random mix of all controls.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r_b = ($urandom_range(149) == 0);
            e_b = ($urandom_range(7) != 0);
            s_b = ($urandom_range(49) == 0);
            w_b = ($urandom_range(5) == 0);
            drive_cycle(r_b, e_b, s_b, w_b, int'($urandom_range(7)), int'($urandom_range(4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
